// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path: visible geometry, pixel-address
// width and the rectangle-fill engine state encoding.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int PIX_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } vga_rect_fill_state_t;

endpackage

// File: rtl/vga_rect_clip.sv
// Combinational rectangle clip: clipped column/line ends, empty detect and the
// y*640 row base built from shifts so no multiplier is inferred.
module vga_rect_clip
    import vga_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_V_ACTIVE = V_ACTIVE
) (
    input  logic [9:0]            x,
    input  logic [8:0]            y,
    input  logic [9:0]            w,
    input  logic [8:0]            h,
    output logic [10:0]           xe,
    output logic [9:0]            ye,
    output logic [PIX_ADDR_W-1:0] row_base,
    output logic                  empty
);

    logic [10:0]           x_sum;
    logic [9:0]            y_sum;
    logic [PIX_ADDR_W-1:0] y_ext;

    assign x_sum = {1'b0, x} + {1'b0, w};
    assign y_sum = {1'b0, y} + {1'b0, h};

    assign xe = (x_sum > 11'(P_H_ACTIVE)) ? 11'(P_H_ACTIVE) : x_sum;
    assign ye = (y_sum > 10'(P_V_ACTIVE)) ? 10'(P_V_ACTIVE) : y_sum;

    // 640 = 512 + 128, so the row base is two shifted copies of y.
    assign y_ext    = PIX_ADDR_W'(y);
    assign row_base = (y_ext << 9) + (y_ext << 7);

    assign empty = (w == '0) || (h == '0)
                || ({1'b0, x} >= 11'(P_H_ACTIVE))
                || ({1'b0, y} >= 10'(P_V_ACTIVE));

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: turns one fill command into a clipped stream of
// single-pixel writes on the display write port, one pixel per unstalled clock.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_V_ACTIVE = V_ACTIVE
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iCMD_REQ,
    output logic        oCMD_BUSY,
    input  logic [9:0]  iCMD_X,
    input  logic [8:0]  iCMD_Y,
    input  logic [9:0]  iCMD_W,
    input  logic [8:0]  iCMD_H,
    input  logic [15:0] iCMD_COLOR,
    output logic        oCMD_DONE,
    output logic        oDISP_WR_REQ,
    input  logic        iDISP_WR_BUSY,
    output logic [31:0] oDISP_WR_ADDR,
    output logic [31:0] oDISP_WR_DATA
);

    localparam logic [PIX_ADDR_W-1:0] ROW_PITCH = PIX_ADDR_W'(P_H_ACTIVE);

    vga_rect_fill_state_t state;

    logic [9:0]            cmd_x;
    logic [8:0]            cmd_y;
    logic [9:0]            cmd_w;
    logic [8:0]            cmd_h;
    logic [15:0]           cmd_color;

    logic [10:0]           clip_xe;
    logic [9:0]            clip_ye;
    logic [PIX_ADDR_W-1:0] clip_base;
    logic                  clip_empty;

    logic [10:0]           xe_q;
    logic [9:0]            ye_q;
    logic [PIX_ADDR_W-1:0] base_q;
    logic [10:0]           cx;
    logic [9:0]            cy;
    logic [PIX_ADDR_W-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  req_q;
    logic                  wr_accept;

    vga_rect_clip #(
        .P_H_ACTIVE (P_H_ACTIVE),
        .P_V_ACTIVE (P_V_ACTIVE)
    ) u_clip (
        .x        (cmd_x),
        .y        (cmd_y),
        .w        (cmd_w),
        .h        (cmd_h),
        .xe       (clip_xe),
        .ye       (clip_ye),
        .row_base (clip_base),
        .empty    (clip_empty)
    );

    assign wr_accept = req_q && !iDISP_WR_BUSY;

    // NOTE: every register, datapath included, is cleared on reset so the
    // address and data outputs read zero straight after reset, not stale values.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            base_q    <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
            cx        <= '0;
            cy        <= '0;
            cmd_x     <= '0;
            cmd_y     <= '0;
            cmd_w     <= '0;
            cmd_h     <= '0;
            cmd_color <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iCMD_REQ) begin
                        cmd_x     <= iCMD_X;
                        cmd_y     <= iCMD_Y;
                        cmd_w     <= iCMD_W;
                        cmd_h     <= iCMD_H;
                        cmd_color <= iCMD_COLOR;
                        busy_q    <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    xe_q   <= clip_xe;
                    ye_q   <= clip_ye;
                    base_q <= clip_base;
                    cx     <= {1'b0, cmd_x};
                    cy     <= {1'b0, cmd_y};
                    addr_q <= clip_base + PIX_ADDR_W'(cmd_x);
                    if (clip_empty) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        req_q  <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Row wrap and the final pixel resolve in the accept cycle,
                    // so the stream never inserts a bubble.
                    if (wr_accept) begin
                        if (cx + 11'd1 < xe_q) begin
                            cx     <= cx + 11'd1;
                            addr_q <= addr_q + 1'b1;
                        end else if (cy + 10'd1 < ye_q) begin
                            cx     <= {1'b0, cmd_x};
                            cy     <= cy + 10'd1;
                            base_q <= base_q + ROW_PITCH;
                            addr_q <= base_q + ROW_PITCH + PIX_ADDR_W'(cmd_x);
                        end else begin
                            req_q  <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oCMD_BUSY     = busy_q;
    assign oCMD_DONE     = done_q;
    assign oDISP_WR_REQ  = req_q;
    assign oDISP_WR_ADDR = {{(32 - PIX_ADDR_W){1'b0}}, addr_q};
    assign oDISP_WR_DATA = {16'h0000, cmd_color};

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: directed plan cases plus randomized
// commands and stalls, checked against a pixel-list reference model.
module tb_vga_rect_fill;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC;
    logic        iCMD_REQ;
    logic        oCMD_BUSY;
    logic [9:0]  iCMD_X;
    logic [8:0]  iCMD_Y;
    logic [9:0]  iCMD_W;
    logic [8:0]  iCMD_H;
    logic [15:0] iCMD_COLOR;
    logic        oCMD_DONE;
    logic        oDISP_WR_REQ;
    logic        iDISP_WR_BUSY;
    logic [31:0] oDISP_WR_ADDR;
    logic [31:0] oDISP_WR_DATA;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam int CYCLE_LIMIT = 3000;

    vga_rect_fill dut (
        .iCLOCK        (iCLOCK),
        .iRESET_SYNC   (iRESET_SYNC),
        .iCMD_REQ      (iCMD_REQ),
        .oCMD_BUSY     (oCMD_BUSY),
        .iCMD_X        (iCMD_X),
        .iCMD_Y        (iCMD_Y),
        .iCMD_W        (iCMD_W),
        .iCMD_H        (iCMD_H),
        .iCMD_COLOR    (iCMD_COLOR),
        .oCMD_DONE     (oCMD_DONE),
        .oDISP_WR_REQ  (oDISP_WR_REQ),
        .iDISP_WR_BUSY (iDISP_WR_BUSY),
        .oDISP_WR_ADDR (oDISP_WR_ADDR),
        .oDISP_WR_DATA (oDISP_WR_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(oCMD_BUSY), 32'd0);
        check({tag, "_done"}, 32'(oCMD_DONE), 32'd0);
        check({tag, "_req"},  32'(oDISP_WR_REQ), 32'd0);
    endtask

    // mode 0: never stall; 1: random stalls; 2: three stalls on address 12812
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [15:0] col, input int mode);
        int exp_q[$];
        int x_end, y_end, cyc, stalls, stall_left, exp_len;
        bit done_seen, prev_stall;
        logic [31:0] prev_addr, prev_data, exp_addr;

        // Reference: every visible pixel of the rectangle, row-major order.
        x_end = (x + w > 640) ? 640 : x + w;
        y_end = (y + h > 480) ? 480 : y + h;
        for (int yy = y; yy < y_end; yy++)
            for (int xx = x; xx < x_end; xx++)
                exp_q.push_back(yy * 640 + xx);
        exp_len = exp_q.size();

        @(negedge iCLOCK);
        check("pre_cmd_busy", 32'(oCMD_BUSY), 32'd0);
        iCMD_X     = 10'(x);
        iCMD_Y     = 9'(y);
        iCMD_W     = 10'(w);
        iCMD_H     = 9'(h);
        iCMD_COLOR = col;
        iCMD_REQ   = 1'b1;
        iDISP_WR_BUSY = 1'b0;

        @(negedge iCLOCK);
        iCMD_REQ = 1'b0;
        check("setup_busy", 32'(oCMD_BUSY), 32'd1);
        check("setup_req",  32'(oDISP_WR_REQ), 32'd0);

        cyc = 1; stalls = 0; stall_left = 3;
        done_seen = 1'b0; prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0;
        while (!done_seen && cyc < CYCLE_LIMIT) begin
            @(negedge iCLOCK);
            cyc++;
            if (prev_stall) begin
                check("hold_req",  32'(oDISP_WR_REQ), 32'd1);
                check("hold_addr", oDISP_WR_ADDR, prev_addr);
                check("hold_data", oDISP_WR_DATA, prev_data);
            end
            case (mode)
                1: iDISP_WR_BUSY = ($urandom_range(0, 3) == 0);
                2: begin
                    iDISP_WR_BUSY = (oDISP_WR_ADDR == 32'd12812) && (stall_left > 0);
                    if (iDISP_WR_BUSY) stall_left--;
                end
                default: iDISP_WR_BUSY = 1'b0;
            endcase
            if (oCMD_DONE) begin
                done_seen = 1'b1;
                iDISP_WR_BUSY = 1'b0;
                check("done_cycle", 32'(cyc), 32'(2 + exp_len + stalls));
                check("writes_left", 32'(exp_q.size()), 32'd0);
                check("done_req", 32'(oDISP_WR_REQ), 32'd0);
                check("done_busy", 32'(oCMD_BUSY), 32'd1);
            end else begin
                check("run_busy", 32'(oCMD_BUSY), 32'd1);
                check("run_req",  32'(oDISP_WR_REQ), 32'd1);
                prev_stall = 1'b0;
                if (oDISP_WR_REQ) begin
                    if (iDISP_WR_BUSY) begin
                        stalls++;
                        prev_stall = 1'b1;
                        prev_addr  = oDISP_WR_ADDR;
                        prev_data  = oDISP_WR_DATA;
                    end else if (exp_q.size() == 0) begin
                        check("extra_write", oDISP_WR_ADDR, 32'hFFFF_FFFF);
                    end else begin
                        exp_addr = 32'(exp_q.pop_front());
                        check("wr_addr", oDISP_WR_ADDR, exp_addr);
                        check("wr_data", oDISP_WR_DATA, {16'h0000, col});
                    end
                end
            end
        end
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);

        @(negedge iCLOCK);
        check_idle_outputs("post_done");
    endtask

    task automatic mid_reset_test();
        int accepts;
        int cyc;
        @(negedge iCLOCK);
        iCMD_X = 10'd5; iCMD_Y = 9'd5; iCMD_W = 10'd4; iCMD_H = 9'd4;
        iCMD_COLOR = 16'h0F0F; iCMD_REQ = 1'b1; iDISP_WR_BUSY = 1'b0;
        @(negedge iCLOCK);
        iCMD_REQ = 1'b0;
        accepts = 0; cyc = 0;
        while (accepts < 2 && cyc < 20) begin
            @(negedge iCLOCK);
            cyc++;
            if (oDISP_WR_REQ) accepts++;
        end
        check("mid_accepts", 32'(accepts), 32'd2);
        // Two writes taken; reset lands on the edge after the second accept.
        @(negedge iCLOCK);
        check("mid_req_before_rst", 32'(oDISP_WR_REQ), 32'd1);
        iRESET_SYNC = 1'b1;
        @(negedge iCLOCK);
        check_idle_outputs("mid_rst");
        check("mid_rst_addr", oDISP_WR_ADDR, 32'd0);
        check("mid_rst_data", oDISP_WR_DATA, 32'd0);
        iRESET_SYNC = 1'b0;
        run_cmd(0, 0, 1, 1, 16'h1234, 0);
    endtask

    initial begin
        iRESET_SYNC   = 1'b1;
        iCMD_REQ      = 1'b1;
        iCMD_X        = 10'd1;
        iCMD_Y        = 9'd1;
        iCMD_W        = 10'd1;
        iCMD_H        = 9'd1;
        iCMD_COLOR    = 16'hFFFF;
        iDISP_WR_BUSY = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge iCLOCK);
            check_idle_outputs("reset");
            check("reset_addr", oDISP_WR_ADDR, 32'd0);
            check("reset_data", oDISP_WR_DATA, 32'd0);
        end
        iRESET_SYNC = 1'b0;
        iCMD_REQ    = 1'b0;

        run_cmd(10, 20, 3, 2, 16'hF800, 0);
        run_cmd(10, 20, 3, 2, 16'hF800, 2);
        run_cmd(638, 479, 5, 4, 16'h07E0, 0);
        run_cmd(100, 100, 0, 3, 16'h001F, 0);
        run_cmd(700, 10, 4, 2, 16'h001F, 0);
        run_cmd(5, 500, 4, 2, 16'hAAAA, 0);
        mid_reset_test();

        for (int n = 0; n < 25; n++) begin
            int x, y, w, h;
            x = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 700) : $urandom_range(630, 645);
            y = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 511) : $urandom_range(474, 485);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 5);
            run_cmd(x, y, w, h, 16'($urandom), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
